// File: rtl/cfg_loader_pkg.sv
// cfg_loader_pkg: shared types and widths for the SelfWrite configuration loader.
package cfg_loader_pkg;
    localparam int LANE_W         = 8;
    localparam int WORD_W         = 32;
    localparam int BYTES_PER_WORD = 4;
    localparam int WC_W           = 13;
    localparam int GAP_W          = 8;
    typedef enum logic [2:0] {IDLE, COLLECT, SETUP, STROBE, HOLD, DONE} state_e;
endpackage

// File: rtl/cfg_gap_timer.sv
// cfg_gap_timer: loadable down-counter timing the SETUP and HOLD gaps around each strobe.
module cfg_gap_timer
    import cfg_loader_pkg::*;
(
    input  logic             CLK,
    input  logic             resetn,
    input  logic             load_i,
    input  logic [GAP_W-1:0] load_val_i,
    input  logic             en_i,
    output logic             zero_o
);
    logic [GAP_W-1:0] cnt_q, cnt_d;
    always_comb cnt_d = load_i ? load_val_i : (en_i && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
    always_ff @(posedge CLK or negedge resetn)
        if (!resetn) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/self_write_loader.sv
// self_write_loader: packs a byte stream MSB-first into 32-bit words and strobes each
// into the fabric SelfWrite port with fixed setup/hold spacing.
module self_write_loader
    import cfg_loader_pkg::*;
#(
    parameter int SETUP_CYCLES = 2,
    parameter int HOLD_CYCLES  = 2,
    parameter int MAX_WORDS    = 5000
) (
    input  logic              CLK,
    input  logic              resetn,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [LANE_W-1:0] byte_data,
    input  logic              byte_last,
    output logic              byte_ready,
    output logic [WORD_W-1:0] SelfWriteData,
    output logic              SelfWriteStrobe,
    output logic              busy,
    output logic              done,
    output logic [WC_W-1:0]   word_count
);
    localparam logic [WC_W-1:0]  MAXW      = WC_W'(MAX_WORDS);
    localparam logic [1:0]       LAST_LANE = 2'(BYTES_PER_WORD - 1);
    state_e            state_q, state_d;
    logic [1:0]        lane_q, lane_d;
    logic [WORD_W-1:0] pack_q, pack_d, data_q, data_d, merged;
    logic [WC_W-1:0]   wc_q, wc_d;
    logic              last_q, last_d, busy_q, done_q;
    logic              xfer, tmr_load, tmr_zero;
    logic [GAP_W-1:0]  tmr_val;
    cfg_gap_timer u_gap (
        .CLK        (CLK),
        .resetn     (resetn),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .en_i       (state_q == SETUP || state_q == HOLD),
        .zero_o     (tmr_zero)
    );
    assign byte_ready = (state_q == COLLECT);
    assign xfer       = byte_valid && byte_ready;
    // lanes not yet written stay zero, so a short final word is padded for free
    assign merged     = pack_q | ({byte_data, 24'h0} >> {lane_q, 3'b000});
    always_comb begin
        state_d  = state_q;
        lane_d   = lane_q;
        pack_d   = pack_q;
        data_d   = data_q;
        last_d   = last_q;
        wc_d     = wc_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        case (state_q)
            IDLE, DONE: if (start) begin
                state_d = COLLECT;
                lane_d  = '0;
                pack_d  = '0;
                wc_d    = '0;
            end
            COLLECT: if (xfer) begin
                lane_d = lane_q + 2'd1;
                pack_d = merged;
                if (lane_q == LAST_LANE || byte_last) begin
                    state_d  = SETUP;
                    lane_d   = '0;
                    pack_d   = '0;
                    data_d   = merged;
                    last_d   = byte_last;
                    tmr_load = 1'b1;
                    tmr_val  = GAP_W'(SETUP_CYCLES - 1);
                end
            end
            SETUP:   state_d = tmr_zero ? STROBE : SETUP;
            STROBE: begin
                state_d  = HOLD;
                wc_d     = (wc_q < MAXW) ? wc_q + 1'b1 : wc_q;
                tmr_load = 1'b1;
                tmr_val  = GAP_W'(HOLD_CYCLES - 1);
            end
            HOLD:    state_d = !tmr_zero ? HOLD : (last_q || wc_q >= MAXW) ? DONE : COLLECT;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            lane_q  <= '0;
            pack_q  <= '0;
            data_q  <= '0;
            last_q  <= 1'b0;
            wc_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            pack_q  <= pack_d;
            data_q  <= data_d;
            last_q  <= last_d;
            wc_q    <= wc_d;
            busy_q  <= (state_d == COLLECT || state_d == SETUP || state_d == STROBE || state_d == HOLD);
            done_q  <= (state_d == DONE);
        end
    end
    assign SelfWriteData   = data_q;
    assign SelfWriteStrobe = (state_q == STROBE);
    assign busy            = busy_q;
    assign done            = done_q;
    assign word_count      = wc_q;
endmodule

// File: tb/tb_self_write_loader.sv
// tb_self_write_loader: randomized scenarios checked against a byte-to-word packing model.
module tb_self_write_loader;
    typedef logic [7:0]  bq_t[$];
    typedef logic [31:0] wq_t[$];
    localparam int SETUP = 2;
    localparam int HOLD  = 2;
    logic CLK = 0, resetn = 0, start = 0, byte_valid = 0, byte_last = 0, sel = 0;
    logic [7:0] byte_data = 0;
    logic rdy_a, sws_a, bsy_a, dn_a, rdy_b, sws_b, bsy_b, dn_b;
    logic [31:0] swd_a, swd_b;
    logic [12:0] wc_a, wc_b;
    logic rdy, sws, bsy, dn;
    logic [31:0] swd;
    logic [12:0] wc;
    int passed = 0, total = 0;
    int cyc = 0, last_chg = -100, last_stb = -100, err_setup = 0, err_hold = 0, err_rdy = 0;
    logic [31:0] prev_d = 0;
    wq_t got_q;
    int stb_cyc[$];

    self_write_loader u_a (
        .CLK(CLK), .resetn(resetn), .start(start), .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_last(byte_last), .byte_ready(rdy_a), .SelfWriteData(swd_a), .SelfWriteStrobe(sws_a),
        .busy(bsy_a), .done(dn_a), .word_count(wc_a)
    );
    self_write_loader #(.MAX_WORDS(3)) u_b (
        .CLK(CLK), .resetn(resetn), .start(start), .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_last(byte_last), .byte_ready(rdy_b), .SelfWriteData(swd_b), .SelfWriteStrobe(sws_b),
        .busy(bsy_b), .done(dn_b), .word_count(wc_b)
    );
    assign rdy = sel ? rdy_b : rdy_a;
    assign sws = sel ? sws_b : sws_a;
    assign bsy = sel ? bsy_b : bsy_a;
    assign dn  = sel ? dn_b  : dn_a;
    assign swd = sel ? swd_b : swd_a;
    assign wc  = sel ? wc_b  : wc_a;

    always #5 CLK = ~CLK;

    // records strobed words and flags setup/hold/ready protocol violations
    always @(negedge CLK) begin
        cyc    <= cyc + 1;
        prev_d <= swd;
        if (resetn) begin
            if (swd !== prev_d) begin
                last_chg <= cyc;
                if (cyc - last_stb <= HOLD) err_hold <= err_hold + 1;
            end
            if (sws) begin
                got_q.push_back(swd);
                stb_cyc.push_back(cyc);
                last_stb <= cyc;
                if (cyc - last_chg < SETUP) err_setup <= err_setup + 1;
            end
            if (rdy && (sws || !bsy || dn)) err_rdy <= err_rdy + 1;
        end
    end

    function automatic wq_t model(input bq_t b, input int maxw);
        wq_t w;
        for (int i = 0; i < b.size(); i++) begin
            if (i % 4 == 0) w.push_back('0);
            w[i/4] = w[i/4] | (32'(b[i]) << (24 - 8 * (i % 4)));
        end
        while (w.size() > maxw) void'(w.pop_back());
        return w;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset(input logic s);
        resetn = 0; start = 0; byte_valid = 0; byte_last = 0; byte_data = 0; sel = s;
        repeat (2) tick();
        resetn = 1;
        tick();
        got_q.delete();
        stb_cyc.delete();
    endtask

    task automatic pulse_start();
        start = 1;
        tick();
        start = 0;
    endtask

    task automatic send(input bq_t b, input bit with_last, input int gap);
        int g, t;
        bit acc;
        for (int i = 0; i < b.size(); i++) begin
            g = gap > 0 ? int'($urandom_range(gap, 0)) : 0;
            repeat (g) begin byte_valid = 0; byte_data = 8'($urandom); tick(); end
            byte_valid = 1; byte_data = b[i]; byte_last = with_last && (i == b.size() - 1);
            t = 0;
            do begin acc = rdy; tick(); t++; end while (!acc && t < 200);
            if (!acc) begin
                total++;
                $display("FAIL send_timeout byte %0d not accepted within 200 cycles", i);
                byte_valid = 0; byte_last = 0;
                return;
            end
        end
        byte_valid = 0; byte_last = 0;
    endtask

    task automatic wait_done();
        for (int t = 0; t < 100 && !dn; t++) tick();
    endtask

    task automatic test_reset();
        resetn = 0; start = 0; byte_valid = 0;
        #3;
        total++;
        if ({rdy, swd, sws, bsy, dn, wc} !== '0) $display("FAIL reset_outputs got %h required 0", {rdy, swd, sws, bsy, dn, wc});
        else passed++;
        do_reset(0);
        total++;
        if ({rdy, swd, sws, bsy, dn, wc} !== '0) $display("FAIL idle_outputs got %h required 0", {rdy, swd, sws, bsy, dn, wc});
        else passed++;
    endtask

    task automatic test_single_word();
        logic [7:0] bytes_v [4] = '{8'h12, 8'h34, 8'h56, 8'h78};
        logic [3:0] stb_seen;
        do_reset(0);
        pulse_start();
        total++;
        if (bsy !== 1'b1 || rdy !== 1'b1) $display("FAIL start_busy got busy=%b ready=%b required 1 1", bsy, rdy);
        else passed++;
        for (int i = 0; i < 4; i++) begin byte_valid = 1; byte_data = bytes_v[i]; tick(); end
        byte_valid = 0;
        total++;
        if (swd !== 32'h12345678) $display("FAIL word_data got %h required 12345678", swd);
        else passed++;
        total++;
        if (rdy !== 1'b0) $display("FAIL ready_in_setup got %b required 0", rdy);
        else passed++;
        stb_seen[0] = sws;
        for (int i = 1; i < 4; i++) begin tick(); stb_seen[i] = sws; end
        total++;
        if (stb_seen !== 4'b0100) $display("FAIL strobe_timing got %b required 0100", stb_seen);
        else passed++;
        total++;
        if (wc !== 13'd1) $display("FAIL word_count_one got %0d required 1", wc);
        else passed++;
        repeat (3) tick();
        pulse_start();
        repeat (2) tick();
        total++;
        if (wc !== 13'd1 || bsy !== 1'b1 || dn !== 1'b0) $display("FAIL start_while_busy got wc=%0d busy=%b done=%b required 1 1 0", wc, bsy, dn);
        else passed++;
    endtask

    task automatic test_two_words();
        bq_t b;
        wq_t exp;
        do_reset(0);
        for (int i = 0; i < 8; i++) b.push_back(8'($urandom));
        exp = model(b, 5000);
        pulse_start();
        send(b, 1, 0);
        wait_done();
        total++;
        if (dn !== 1'b1 || bsy !== 1'b0) $display("FAIL two_words_done got done=%b busy=%b required 1 0", dn, bsy);
        else passed++;
        total++;
        if (wc !== 13'd2) $display("FAIL two_words_count got %0d required 2", wc);
        else passed++;
        total++;
        if (got_q.size() != exp.size()) $display("FAIL two_words_n got %0d required %0d", got_q.size(), exp.size());
        else passed++;
        for (int i = 0; i < got_q.size() && i < exp.size(); i++) begin
            total++;
            if (got_q[i] !== exp[i]) $display("FAIL two_words_w%0d got %h required %h", i, got_q[i], exp[i]);
            else passed++;
        end
        if (stb_cyc.size() >= 2) begin
            total++;
            if (stb_cyc[1] - stb_cyc[0] < 9) $display("FAIL strobe_spacing got %0d required >=9", stb_cyc[1] - stb_cyc[0]);
            else passed++;
        end
    endtask

    task automatic test_padding();
        bq_t b = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
        wq_t exp = model(b, 5000);
        do_reset(0);
        start = 1; byte_valid = 1; byte_data = 8'hAA;
        total++;
        if (rdy !== 1'b0) $display("FAIL idle_start_ready got %b required 0", rdy);
        else passed++;
        tick();
        start = 0;
        send(b, 1, 0);
        wait_done();
        total++;
        if (got_q.size() != 2 || dn !== 1'b1) $display("FAIL pad_count got n=%0d done=%b required 2 1", got_q.size(), dn);
        else passed++;
        for (int i = 0; i < got_q.size() && i < exp.size(); i++) begin
            total++;
            if (got_q[i] !== exp[i]) $display("FAIL pad_w%0d got %h required %h", i, got_q[i], exp[i]);
            else passed++;
        end
    endtask

    task automatic test_stalls();
        bq_t b;
        wq_t exp;
        do_reset(0);
        for (int i = 0; i < 23; i++) b.push_back(8'($urandom));
        exp = model(b, 5000);
        pulse_start();
        send(b, 1, 3);
        wait_done();
        total++;
        if (got_q.size() != exp.size()) $display("FAIL stall_n got %0d required %0d", got_q.size(), exp.size());
        else passed++;
        for (int i = 0; i < got_q.size() && i < exp.size(); i++) begin
            total++;
            if (got_q[i] !== exp[i]) $display("FAIL stall_w%0d got %h required %h", i, got_q[i], exp[i]);
            else passed++;
        end
        total++;
        if (err_setup != 0 || err_hold != 0) $display("FAIL data_stability got setup_err=%0d hold_err=%0d required 0 0", err_setup, err_hold);
        else passed++;
        total++;
        if (err_rdy != 0) $display("FAIL ready_outside_collect got %0d required 0", err_rdy);
        else passed++;
    endtask

    task automatic test_reset_mid_word();
        bq_t b, c;
        wq_t exp;
        do_reset(0);
        for (int i = 0; i < 6; i++) b.push_back(8'($urandom));
        for (int i = 0; i < 4; i++) c.push_back(8'($urandom));
        exp = model(c, 5000);
        pulse_start();
        send(b, 0, 0);
        tick();
        #2 resetn = 0;
        #1;
        total++;
        if ({rdy, swd, sws, bsy, dn, wc} !== '0) $display("FAIL midword_reset got %h required 0", {rdy, swd, sws, bsy, dn, wc});
        else passed++;
        total++;
        if (got_q.size() != 1) $display("FAIL midword_strobes got %0d required 1", got_q.size());
        else passed++;
        tick();
        resetn = 1;
        tick();
        got_q.delete();
        pulse_start();
        send(c, 1, 0);
        wait_done();
        total++;
        if (got_q.size() != 1 || wc !== 13'd1) $display("FAIL after_reset_n got n=%0d wc=%0d required 1 1", got_q.size(), wc);
        else passed++;
        if (got_q.size() > 0) begin
            total++;
            if (got_q[0] !== exp[0]) $display("FAIL after_reset_word got %h required %h", got_q[0], exp[0]);
            else passed++;
        end
    endtask

    task automatic test_max_words();
        bq_t b, tail;
        wq_t exp, exp_tail;
        int nrdy = 0;
        do_reset(1);
        for (int i = 0; i < 16; i++) b.push_back(8'($urandom));
        for (int i = 12; i < 16; i++) tail.push_back(b[i]);
        exp = model(b, 3);
        exp_tail = model(tail, 3);
        pulse_start();
        send(b[0:11], 0, 1);
        wait_done();
        total++;
        if (dn !== 1'b1 || bsy !== 1'b0 || wc !== 13'd3) $display("FAIL max_done got done=%b busy=%b wc=%0d required 1 0 3", dn, bsy, wc);
        else passed++;
        total++;
        if (got_q.size() != 3) $display("FAIL max_n got %0d required 3", got_q.size());
        else passed++;
        for (int i = 0; i < got_q.size() && i < exp.size(); i++) begin
            total++;
            if (got_q[i] !== exp[i]) $display("FAIL max_w%0d got %h required %h", i, got_q[i], exp[i]);
            else passed++;
        end
        byte_valid = 1; byte_data = b[12];
        for (int i = 0; i < 10; i++) begin if (rdy) nrdy++; tick(); end
        total++;
        if (nrdy != 0) $display("FAIL ready_in_done got %0d cycles required 0", nrdy);
        else passed++;
        pulse_start();
        byte_valid = 0;
        total++;
        if (wc !== 13'd0 || bsy !== 1'b1 || dn !== 1'b0) $display("FAIL restart got wc=%0d busy=%b done=%b required 0 1 0", wc, bsy, dn);
        else passed++;
        got_q.delete();
        send(tail, 1, 0);
        wait_done();
        total++;
        if (got_q.size() != 1 || wc !== 13'd1) $display("FAIL restart_n got n=%0d wc=%0d required 1 1", got_q.size(), wc);
        else passed++;
        if (got_q.size() > 0) begin
            total++;
            if (got_q[0] !== exp_tail[0]) $display("FAIL restart_word got %h required %h", got_q[0], exp_tail[0]);
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_two_words();
        test_padding();
        test_stalls();
        test_reset_mid_word();
        test_max_words();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
